clk_divider_multi: RTL and testbench
====================================

CLK_DIVIDER_MULTI -- requirements
Module: clk_divider_multi

Interface
REQ-001 The block SHALL have the parameter CHANNELS, default 4: number of independent divider channels.
REQ-002 The block SHALL have the parameter WIDTH, default 16: bit width of each divider, phase and counter value.
REQ-003 The block SHALL have the parameter DEFAULT_DIV, default 2: active divide ratio applied at reset.
REQ-004 Port clk_in  input  1: the only clock; all registers SHALL be clocked on its rising edge.
REQ-005 Port rst  input  1: asynchronous, active-high reset.
REQ-006 Port en  input  CHANNELS: per-channel run enable.
REQ-007 Port divider  input  CHANNELS*WIDTH: requested divide ratio D per channel; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port phase  input  CHANNELS*WIDTH: requested start count per channel, packed like divider.
REQ-009 Port mode  input  CHANNELS: per channel, 0 = square output, 1 = one-cycle pulse output.
REQ-010 Port load  input  CHANNELS: single-cycle strobe that captures divider[i] and phase[i] into the pending registers.
REQ-011 Port sync  input  1: single-cycle strobe that realigns all channels.
REQ-012 Port clk_out  output  CHANNELS: divided clock per channel.
REQ-013 Port tick  output  CHANNELS: registered end-of-period strobe per channel.
REQ-014 Port aux  output  WIDTH: debug copy of the channel 0 counter.

Function
REQ-015 Each channel SHALL hold these registers: cnt (WIDTH bits), active ratio Da, active phase Pa, pending ratio Dp, pending phase Pp, pending flag pf, and a run state (STOPPED or RUNNING).
REQ-016 Load: load[i]=1 SHALL capture divider/phase into Dp/Pp and set pf; if load is asserted again before transfer, the new values SHALL overwrite the old.
REQ-017 Pending transfer: Da/Pa SHALL take Dp/Pp and pf SHALL clear at the period boundary (cnt==Da-1 while RUNNING), at sync, or in any cycle the channel is STOPPED.
REQ-018 Counting (Da>=2, RUNNING): cnt SHALL advance 0,1,..,Da-1 and wrap to 0; all arithmetic is unsigned WIDTH-bit.
REQ-019 Square mode: clk_out[i] SHALL be registered and equal 1 in exactly the cycles where cnt < ceil(Da/2).
  - Even Da gives 50% duty.
  - Odd Da is high one cycle longer than low.
REQ-020 Pulse mode: clk_out[i] SHALL be 1 only in the cycle where cnt==0.
REQ-021 tick[i] SHALL be 1 in exactly the cycle where cnt==Da-1 while RUNNING, and 0 otherwise.
REQ-022 Start: a STOPPED channel with en[i]=1 SHALL enter RUNNING with cnt=0 on the next edge; the first output cycle has cnt=0.
REQ-023 Glitch-free stop: en[i]=0 while RUNNING SHALL let the channel finish its current period, then enter STOPPED at the wrap, holding cnt=0, clk_out=0 and tick=0.
REQ-024 Bypass (Da<=1): clk_out[i] SHALL equal clk_in & en[i] combinationally, tick[i] SHALL equal en[i] registered, and cnt SHALL hold 0.
REQ-025 Sync: sync=1 SHALL first apply pending values, then set every RUNNING channel's cnt to Pa, or to 0 if Pa>=Da.
  - Outputs SHALL follow the new cnt from the next cycle.
  - STOPPED channels are unaffected apart from the pending transfer.
REQ-026 Simultaneous events: if sync coincides with a boundary, sync SHALL win; load and transfer in the same cycle SHALL transfer the old Dp and keep the new value pending.
REQ-027 A change of mode[i] SHALL take effect on the next edge without disturbing cnt.
REQ-028 aux SHALL equal cnt of channel 0.

Reset
REQ-029 rst=1 SHALL asynchronously force, per channel: cnt=0, Da=Dp=DEFAULT_DIV, Pa=Pp=0, pf=0, state STOPPED, clk_out=0, tick=0, aux=0.
REQ-030 Release of rst SHALL be sampled synchronously; a channel with en=1 at release SHALL start on the first edge after release.
REQ-031 Asserting rst mid-period SHALL discard the period and any pending load.

Verification
REQ-032 D=4, square mode, en=1 -> clk_out 1,1,0,0 repeating; tick every 4th cycle, aligned with cnt==3.
REQ-033 D=5, square mode -> clk_out high for 3 cycles and low for 2; in pulse mode -> one-cycle pulses every 5 cycles.
REQ-034 Running D=4, load D=6 at cnt=1 -> the current period completes with 4 cycles, then 6-cycle periods follow.
REQ-035 Ch0 and ch1 at D=8 with phases 0 and 4, sync pulse -> clk_out[1] is 180 degrees out of phase with clk_out[0]; phase=9 with D=8 -> cnt 0.
REQ-036 en dropped at cnt=2 with D=6 -> the channel runs through cnt=5 and stops with clk_out=0; re-enable -> restart at cnt=0.
REQ-037 D=1 with en toggling -> clk_out tracks clk_in & en; rst asserted mid-period -> all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/clk_divider_multi.sv
// clk_divider_multi: bank of independent programmable clock dividers.
//
// Each channel counts 0..Da-1 and emits a square or one-cycle-pulse output plus an
// end-of-period tick. New ratio/phase values are double-buffered: load captures them
// as pending, and they become active only at a period boundary, on sync, or while the
// channel is stopped, so running outputs never glitch on reprogramming.
//
// Ports:
//   clk_in   - the only clock, rising-edge
//   rst      - asynchronous active-high reset
//   en       - per-channel run enable (stop is deferred to the end of the period)
//   divider  - per-channel requested ratio, channel i at [i*WIDTH +: WIDTH]
//   phase    - per-channel requested start count, packed like divider
//   mode     - per-channel 0 = square, 1 = pulse at cnt==0
//   load     - per-channel strobe capturing divider/phase into the pending registers
//   sync     - global strobe: apply pending values, then reload running counters
//   clk_out  - per-channel divided clock (bypassed to clk_in & en when ratio <= 1)
//   tick     - per-channel registered end-of-period strobe
//   aux      - channel 0 counter, for debug
module clk_divider_multi #(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic                      clk_in,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS*WIDTH-1:0] divider,
   input  logic [CHANNELS*WIDTH-1:0] phase,
   input  logic [CHANNELS-1:0]       mode,
   input  logic [CHANNELS-1:0]       load,
   input  logic                      sync,
   output logic [CHANNELS-1:0]       clk_out,
   output logic [CHANNELS-1:0]       tick,
   output logic [WIDTH-1:0]          aux
);

   typedef enum logic {
      StStopped = 1'b0,
      StRunning = 1'b1
   } run_state_e;

   localparam logic [WIDTH-1:0] OneW   = WIDTH'(1);
   localparam logic [WIDTH-1:0] DivRst = WIDTH'(DEFAULT_DIV);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      run_state_e       r_state;
      run_state_e       w_state_d;
      logic [WIDTH-1:0] r_cnt, w_cnt_d;
      logic [WIDTH-1:0] r_da, w_da_d;
      logic [WIDTH-1:0] r_pa, w_pa_d;
      logic [WIDTH-1:0] r_dp, w_dp_d;
      logic [WIDTH-1:0] r_pp, w_pp_d;
      logic             r_pf, w_pf_d;
      logic             r_clk, w_clk_d;
      logic             r_tick, w_tick_d;
      logic [WIDTH-1:0] w_div_in, w_ph_in, w_half;
      logic             w_byp, w_bound, w_xfer;

      assign w_div_in = divider[i*WIDTH +: WIDTH];
      assign w_ph_in  = phase[i*WIDTH +: WIDTH];

      // In bypass every cycle counts as a period end, so pending values always get
      // a chance to transfer (Da=0 would otherwise never reach cnt==Da-1).
      assign w_byp   = (r_da <= OneW);
      assign w_bound = (r_state == StRunning) && (w_byp || (r_cnt == r_da - OneW));
      assign w_xfer  = r_pf && ((r_state == StStopped) || sync || w_bound);

      // Next-state: pending buffer, active values, run state and counter.
      always_comb begin
         w_dp_d    = r_dp;
         w_pp_d    = r_pp;
         w_pf_d    = r_pf;
         w_da_d    = r_da;
         w_pa_d    = r_pa;
         w_state_d = r_state;
         w_cnt_d   = r_cnt;

         // Transfer reads the old pending value; a same-cycle load stays pending.
         if (w_xfer) begin
            w_da_d = r_dp;
            w_pa_d = r_pp;
            w_pf_d = 1'b0;
         end
         if (load[i]) begin
            w_dp_d = w_div_in;
            w_pp_d = w_ph_in;
            w_pf_d = 1'b1;
         end

         case (r_state)
            StStopped: begin
               w_cnt_d = '0;
               if (en[i]) begin
                  w_state_d = StRunning;
               end
            end
            StRunning: begin
               // sync takes priority over the period boundary and a pending stop
               if (sync) begin
                  w_cnt_d = (w_pa_d >= w_da_d) ? '0 : w_pa_d;
               end else if (w_bound) begin
                  w_cnt_d = '0;
                  if (!en[i]) begin
                     w_state_d = StStopped;
                  end
               end else begin
                  w_cnt_d = r_cnt + OneW;
               end
            end
            default: begin
               w_state_d = StStopped;
               w_cnt_d   = '0;
            end
         endcase
      end

      // ceil(Da/2) without the overflow of (Da+1)>>1 at the top of the range
      assign w_half = (w_da_d >> 1) + {{(WIDTH-1){1'b0}}, w_da_d[0]};

      // Outputs are registered from the next state so they line up with cnt.
      always_comb begin
         w_clk_d  = 1'b0;
         w_tick_d = 1'b0;
         if (w_da_d <= OneW) begin
            w_tick_d = en[i];
         end else if (w_state_d == StRunning) begin
            w_tick_d = (w_cnt_d == w_da_d - OneW);
            w_clk_d  = mode[i] ? (w_cnt_d == '0) : (w_cnt_d < w_half);
         end
      end

      always_ff @(posedge clk_in or posedge rst) begin
         if (rst) begin
            r_state <= StStopped;
            r_cnt   <= '0;
            r_da    <= DivRst;
            r_pa    <= '0;
            r_dp    <= DivRst;
            r_pp    <= '0;
            r_pf    <= 1'b0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
         end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_da    <= w_da_d;
            r_pa    <= w_pa_d;
            r_dp    <= w_dp_d;
            r_pp    <= w_pp_d;
            r_pf    <= w_pf_d;
            r_clk   <= w_clk_d;
            r_tick  <= w_tick_d;
         end
      end

      // Bypass path is combinational from clk_in; rst gates it so reset forces 0.
      assign clk_out[i] = w_byp ? (clk_in & en[i] & ~rst) : r_clk;
      assign tick[i]    = r_tick;

      if (i == 0) begin : g_aux
         assign aux = r_cnt;
      end
   end

endmodule

// File: tb/tb_clk_divider_multi.sv
module tb_clk_divider_multi;

   localparam int CH = 4;
   localparam int W  = 16;

   logic            clk_in;
   logic            rst;
   logic [CH-1:0]   en;
   logic [CH*W-1:0] divider;
   logic [CH*W-1:0] phase;
   logic [CH-1:0]   mode;
   logic [CH-1:0]   load;
   logic            sync;
   logic [CH-1:0]   clk_out;
   logic [CH-1:0]   tick;
   logic [W-1:0]    aux;

   int n_total = 0;
   int n_bad   = 0;

   // Behavioural model: one record of plain integers per channel.
   int unsigned m_cnt [CH];
   int unsigned m_da  [CH];
   int unsigned m_pa  [CH];
   int unsigned m_dp  [CH];
   int unsigned m_pp  [CH];
   bit          m_pf  [CH];
   bit          m_run [CH];
   bit          m_mode[CH];
   bit          m_en  [CH];

   clk_divider_multi #(
      .CHANNELS   (CH),
      .WIDTH      (W),
      .DEFAULT_DIV(2)
   ) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .en     (en),
      .divider(divider),
      .phase  (phase),
      .mode   (mode),
      .load   (load),
      .sync   (sync),
      .clk_out(clk_out),
      .tick   (tick),
      .aux    (aux)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < CH; c++) begin
         m_cnt[c] = 0; m_da[c] = 2; m_dp[c] = 2; m_pa[c] = 0; m_pp[c] = 0;
         m_pf[c] = 0; m_run[c] = 0; m_mode[c] = 0; m_en[c] = 0;
      end
   endfunction

   // Apply one rising edge's worth of the rules, reading the inputs seen at that edge.
   function automatic void model_step();
      for (int c = 0; c < CH; c++) begin
         bit          period_end;
         bit          take;
         int unsigned old_dp;
         int unsigned old_pp;
         period_end = m_run[c] && ((m_da[c] <= 1) || (m_cnt[c] + 1 == m_da[c]));
         take       = m_pf[c] && (!m_run[c] || sync || period_end);
         old_dp     = m_dp[c];
         old_pp     = m_pp[c];
         if (load[c]) begin
            m_dp[c] = divider[c*W +: W];
            m_pp[c] = phase[c*W +: W];
            m_pf[c] = 1;
         end else if (take) begin
            m_pf[c] = 0;
         end
         if (take) begin
            m_da[c] = old_dp;
            m_pa[c] = old_pp;
         end
         if (!m_run[c]) begin
            m_run[c] = en[c];
            m_cnt[c] = 0;
         end else if (sync) begin
            m_cnt[c] = (m_pa[c] < m_da[c]) ? m_pa[c] : 0;
         end else if (period_end) begin
            m_cnt[c] = 0;
            m_run[c] = en[c];
         end else begin
            m_cnt[c] = m_cnt[c] + 1;
         end
         m_mode[c] = mode[c];
         m_en[c]   = en[c];
      end
   endfunction

   function automatic bit exp_clk(int c, bit lvl);
      if (m_da[c] <= 1) return lvl & en[c];
      if (!m_run[c]) return 1'b0;
      if (m_mode[c]) return m_cnt[c] == 0;
      return (2 * m_cnt[c]) < m_da[c];
   endfunction

   function automatic bit exp_tick(int c);
      if (m_da[c] <= 1) return m_en[c];
      if (!m_run[c]) return 1'b0;
      return m_cnt[c] == m_da[c] - 1;
   endfunction

   // One clock: model follows the edge, outputs checked in the high and low phases.
   task automatic cycle();
      @(posedge clk_in);
      model_step();
      #1;
      for (int c = 0; c < CH; c++) begin
         check_eq($sformatf("clk_hi%0d", c), 32'(clk_out[c]), 32'(exp_clk(c, 1'b1)));
         check_eq($sformatf("tick%0d", c), 32'(tick[c]), 32'(exp_tick(c)));
      end
      check_eq("aux", 32'(aux), m_cnt[0]);
      @(negedge clk_in);
      for (int c = 0; c < CH; c++) begin
         check_eq($sformatf("clk_lo%0d", c), 32'(clk_out[c]), 32'(exp_clk(c, 1'b0)));
      end
   endtask

   function automatic logic [W-1:0] rand_div();
      int unsigned r;
      r = $urandom_range(0, 15);
      if (r == 0) return '0;
      if (r == 1) return W'(1);
      return W'($urandom_range(2, 12));
   endfunction

   initial begin
      bit pat_clk4 [4];
      bit pat_tick4[4];
      pat_clk4  = '{1'b1, 1'b1, 1'b0, 1'b0};
      pat_tick4 = '{1'b0, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; en = '0; divider = '0; phase = '0; mode = '0; load = '0; sync = 1'b0;
      model_reset();
      #7;
      check_eq("rst_clk", 32'(clk_out), 32'd0);
      check_eq("rst_tick", 32'(tick), 32'd0);
      check_eq("rst_aux", 32'(aux), 32'd0);
      @(posedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;

      // D=4 square: 1,1,0,0 with tick on the last count
      for (int c = 0; c < CH; c++) divider[c*W +: W] = W'(4);
      load = '1;
      cycle();
      load = '0;
      cycle();
      en = '1;
      for (int k = 0; k < 8; k++) begin
         cycle();
         check_eq("sq4_clk", 32'(clk_out[0]), 32'(pat_clk4[k % 4]));
         check_eq("sq4_tick", 32'(tick[0]), 32'(pat_tick4[k % 4]));
      end

      // D=8, phases 9 (out of range -> 0) and 4, realigned by sync
      for (int c = 0; c < CH; c++) divider[c*W +: W] = W'(8);
      phase[0*W +: W] = W'(9);
      phase[1*W +: W] = W'(4);
      phase[2*W +: W] = W'(2);
      phase[3*W +: W] = W'(7);
      load = '1;
      cycle();
      load = '0;
      sync = 1'b1;
      for (int k = 0; k < 16; k++) begin
         cycle();
         sync = 1'b0;
         check_eq("ph_clk0", 32'(clk_out[0]), 32'((k % 8) < 4));
         check_eq("ph_clk1", 32'(clk_out[1]), 32'(((k + 4) % 8) < 4));
      end

      // Bypass on ch3, then a pending load on ch0, then reset mid-period
      divider[3*W +: W] = W'(1);
      load = 4'b1000;
      cycle();
      load = '0;
      sync = 1'b1;
      cycle();
      sync = 1'b0;
      divider[0*W +: W] = W'(7);
      load = 4'b0001;
      cycle();
      load = '0;
      cycle();
      @(posedge clk_in);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_clk", 32'(clk_out), 32'd0);
      check_eq("arst_tick", 32'(tick), 32'd0);
      check_eq("arst_aux", 32'(aux), 32'd0);
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 6; k++) cycle();

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < CH; c++) begin
            if (en[c]) begin
               if ($urandom_range(0, 24) == 0) en[c] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               en[c] = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) mode[c] = ~mode[c];
            divider[c*W +: W] = rand_div();
            phase[c*W +: W]   = W'($urandom_range(0, 11));
            load[c]           = ($urandom_range(0, 29) == 0);
         end
         sync = ($urandom_range(0, 63) == 0);
         cycle();
      end
      load = '0;
      sync = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
